// File: rtl/adc_frame_packer.sv
// adc_frame_packer
// Drains up to NCH per-channel sample FIFOs into a single byte stream.
// Frame layout: 0x55 0xAA dev_info dev_smpr dev_kind N, then the samples of
// every active channel in ascending channel order (MSB byte first), then an
// 8-bit checksum (sum of every byte from dev_info through the last data byte)
// flagged with tx_last.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   fs_fifo / fd_fifo        frame start request (level) / frame done
//   dev_info/smpr/kind       header fields, sampled while each byte is presented
//   ch_en, ch_len            per-channel enable mask and sample counts (8b each)
//   fifo_rd                  one-hot read strobe, one cycle per sample
//   fifo_dat, fifo_empty     per-channel read data (valid one cycle after
//                            fifo_rd) and empty flags
//   tx_data/valid/ready/last byte stream output
//   err                      sticky underflow flag, cleared on frame start
//   dbg_state                current FSM state
//
// Handshake: a byte moves when tx_valid && tx_ready on a rising clock edge.
// tx_valid never depends on tx_ready; while tx_ready is low, tx_data, tx_valid
// and the FSM state are held.
module adc_frame_packer #(
  parameter int NCH    = 8,
  parameter int SBYTES = 2,
  parameter int MAXS   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fs_fifo,
  output logic                    fd_fifo,
  input  logic [7:0]              dev_info,
  input  logic [7:0]              dev_smpr,
  input  logic [7:0]              dev_kind,
  input  logic [NCH-1:0]          ch_en,
  input  logic [NCH*8-1:0]        ch_len,
  output logic [NCH-1:0]          fifo_rd,
  input  logic [NCH*8*SBYTES-1:0] fifo_dat,
  input  logic [NCH-1:0]          fifo_empty,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    tx_last,
  output logic                    err,
  output logic [2:0]              dbg_state
);

  localparam int SW  = 8 * SBYTES;
  localparam int CW  = $clog2(MAXS + 1);
  localparam int BW  = (SBYTES > 1) ? $clog2(SBYTES) : 1;
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WT   = 3'd3;
  localparam logic [2:0] S_DAT  = 3'd4;
  localparam logic [2:0] S_CSUM = 3'd5;
  localparam logic [2:0] S_LAST = 3'd6;

  logic [2:0]     state;
  logic [NCH-1:0] act;          // active set frozen at frame start
  logic [CW-1:0]  len_q [NCH];  // clamped lengths frozen at frame start
  logic [CHW-1:0] cur;
  logic [CW-1:0]  scnt;         // samples already sent on cur
  logic [2:0]     hidx;
  logic [BW-1:0]  bidx;
  logic [SW-1:0]  sample;
  logic           zero_smp;     // last RD found the FIFO empty
  logic [7:0]     csum;

  logic           xfer;
  logic [NCH-1:0] act_in;
  logic [CW-1:0]  len_in [NCH];
  logic [7:0]     nact;
  logic [SW-1:0]  cur_dat;
  logic           cur_empty;
  logic [CW-1:0]  cur_len;
  logic           first_ok;
  logic [CHW-1:0] first_ch;
  logic           next_ok;
  logic [CHW-1:0] next_ch;
  logic [7:0]     hdr_byte;
  logic [SW-1:0]  dat_sh;

  assign xfer      = tx_valid & tx_ready;
  assign dbg_state = state;

  // Clamp requested lengths to MAXS and form the candidate active set.
  always_comb begin
    act_in = '0;
    for (int i = 0; i < NCH; i++) begin
      len_in[i] = (32'(ch_len[i*8 +: 8]) > MAXS) ? CW'(MAXS) : CW'(ch_len[i*8 +: 8]);
      act_in[i] = ch_en[i] && (ch_len[i*8 +: 8] != 8'd0);
    end
  end

  // Channel count for the N header byte, taken from the frozen set.
  always_comb begin
    nact = 8'd0;
    for (int i = 0; i < NCH; i++) nact = nact + 8'(act[i]);
  end

  // Select the current channel's data, empty flag and length.
  always_comb begin
    cur_dat   = '0;
    cur_empty = 1'b0;
    cur_len   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cur == CHW'(i)) begin
        cur_dat   = fifo_dat[i*SW +: SW];
        cur_empty = fifo_empty[i];
        cur_len   = len_q[i];
      end
    end
  end

  // Lowest active channel, and lowest active channel strictly above cur.
  // Scanning downward lets the last hit win, i.e. the lowest index.
  always_comb begin
    first_ok = 1'b0;
    first_ch = '0;
    next_ok  = 1'b0;
    next_ch  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (act[i]) begin
        first_ok = 1'b1;
        first_ch = CHW'(i);
      end
      if (act[i] && (CHW'(i) > cur)) begin
        next_ok = 1'b1;
        next_ch = CHW'(i);
      end
    end
  end

  always_comb begin
    case (hidx)
      3'd0:    hdr_byte = 8'h55;
      3'd1:    hdr_byte = 8'hAA;
      3'd2:    hdr_byte = dev_info;
      3'd3:    hdr_byte = dev_smpr;
      3'd4:    hdr_byte = dev_kind;
      default: hdr_byte = nact;
    endcase
  end

  // MSB-first byte selection: byte index 0 is the top byte of the sample.
  assign dat_sh = sample >> (8 * (SBYTES - 1 - int'(bidx)));

  always_comb begin
    case (state)
      S_HDR:   tx_data = hdr_byte;
      S_DAT:   tx_data = dat_sh[7:0];
      S_CSUM:  tx_data = csum;
      default: tx_data = 8'h00;
    endcase
  end

  assign tx_valid = (state == S_HDR) || (state == S_DAT) || (state == S_CSUM);
  assign tx_last  = (state == S_CSUM);
  assign fd_fifo  = (state == S_LAST);

  // RD lasts exactly one cycle, so the strobe is one cycle per sample.
  always_comb begin
    fifo_rd = '0;
    for (int i = 0; i < NCH; i++)
      fifo_rd[i] = (state == S_RD) && (cur == CHW'(i)) && !fifo_empty[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      act      <= '0;
      for (int i = 0; i < NCH; i++) len_q[i] <= '0;
      cur      <= '0;
      scnt     <= '0;
      hidx     <= '0;
      bidx     <= '0;
      sample   <= '0;
      zero_smp <= 1'b0;
      csum     <= 8'h00;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fs_fifo) begin
            state <= S_HDR;
            act   <= act_in;
            for (int i = 0; i < NCH; i++) len_q[i] <= len_in[i];
            csum  <= 8'h00;
            err   <= 1'b0;
            hidx  <= '0;
          end
        end
        S_HDR: begin
          if (xfer) begin
            // Sync bytes 0x55/0xAA are not part of the checksum.
            if (hidx >= 3'd2) csum <= csum + tx_data;
            if (hidx == 3'd5) begin
              hidx <= '0;
              scnt <= '0;
              if (first_ok) begin
                cur   <= first_ch;
                state <= S_RD;
              end else begin
                state <= S_CSUM;
              end
            end else begin
              hidx <= hidx + 3'd1;
            end
          end
        end
        S_RD: begin
          // An empty FIFO is not strobed; the sample goes out as zero.
          if (cur_empty) err <= 1'b1;
          zero_smp <= cur_empty;
          state    <= S_WT;
        end
        S_WT: begin
          sample <= zero_smp ? '0 : cur_dat;
          bidx   <= '0;
          state  <= S_DAT;
        end
        S_DAT: begin
          if (xfer) begin
            csum <= csum + tx_data;
            if (bidx == BW'(SBYTES - 1)) begin
              bidx <= '0;
              if ((scnt + CW'(1)) < cur_len) begin
                scnt  <= scnt + CW'(1);
                state <= S_RD;
              end else begin
                scnt <= '0;
                if (next_ok) begin
                  cur   <= next_ch;
                  state <= S_RD;
                end else begin
                  state <= S_CSUM;
                end
              end
            end else begin
              bidx <= bidx + BW'(1);
            end
          end
        end
        S_CSUM: begin
          if (xfer) state <= S_LAST;
        end
        S_LAST: begin
          if (!fs_fifo) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/adc_frame_packer.md
# adc_frame_packer

Parametrised frame packer that drains up to NCH per-channel sample FIFOs into one byte stream for the ADC/uplink path. On each frame request it emits a fixed header, the enabled channels' samples in ascending channel order, and an 8-bit checksum. The output has valid/ready backpressure. Per-channel sample counts are runtime-programmable and replace the earlier fixed 16/32-sample modes.

## Interface
- NCH, 8: number of channel FIFOs (1..16)
- SBYTES, 2: bytes per sample (1..4), sent MSB byte first
- MAXS, 32: maximum samples per channel per frame; ch_len values above MAXS are clamped to MAXS
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- fs_fifo  in  1  frame start request (level)
- fd_fifo  out  1  frame done; high in LAST until fs_fifo drops
- dev_info, dev_smpr, dev_kind  in  8 each  header fields
- ch_en  in  NCH  channel include mask
- ch_len  in  NCH*8  samples per channel; channel i uses bits [8i+7:8i]
- fifo_rd  out  NCH  one-hot read strobe, one cycle per sample
- fifo_dat  in  NCH*8*SBYTES  channel read data; valid the cycle after fifo_rd
- fifo_empty  in  NCH  per-channel empty flag
- tx_data  out  8  output byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts the byte
- tx_last  out  1  marks the checksum byte
- err  out  1  sticky underflow flag

## Operation
- States: IDLE, HDR, RD, WT, DAT, CSUM, LAST.
- IDLE → HDR when fs_fifo=1.
  - On this transition, snapshot ch_en and clamped ch_len.
  - Active set = channels with en=1 and len≠0.
  - Clear checksum and err.
- HDR emits 6 bytes: 0x55, 0xAA, dev_info, dev_smpr, dev_kind, N. N = popcount of the active set.
  - Header fields are sampled at the moment each byte is presented.
  - Last header byte accepted → RD on the lowest active channel, or → CSUM if the set is empty.
- RD: pulse fifo_rd[cur] for 1 cycle, unless fifo_empty[cur]=1. In that case, no strobe, set err, and the sample is replaced by 0.
- RD → WT.
- WT: capture the SBYTES bytes of fifo_dat for cur into the sample register. WT → DAT.
- DAT emits SBYTES bytes, MSB first. When the final byte of a sample is accepted:
  - more samples remain on cur → RD;
  - otherwise → RD on the next active channel above cur;
  - if none remain → CSUM.
- CSUM emits the checksum with tx_last=1. On acceptance → LAST.
- Checksum = sum mod 256 of every byte from dev_info through the last data byte. 0x55 and 0xAA are excluded.
- LAST: fd_fifo=1. LAST → IDLE when fs_fifo=0.
- fs_fifo dropping mid-frame is ignored; the frame always completes.
- A byte transfers when tx_valid&tx_ready. While tx_ready=0, hold tx_data, tx_valid and the state.
- tx_valid=1 only in HDR, DAT and CSUM.
- Counters: sample count uses clog2(MAXS+1) bits, byte index uses clog2(SBYTES) bits. No wrap-around is permitted.

## Timing
- Reset values: fd_fifo=0, fifo_rd=0, tx_data=0x00, tx_valid=0, tx_last=0, err=0, state=IDLE.
- Reset mid-frame aborts immediately. No checksum byte is emitted.
- fs_fifo high in IDLE → first header byte valid on the next cycle.
- Per-sample cost with tx_ready=1: 2 bubble cycles (RD, WT) plus SBYTES byte cycles.
- Frame length = 7 + SBYTES·Σlen(active) bytes.
- fifo_rd is never asserted outside RD and never for more than 1 cycle per sample, regardless of tx_ready.
- err is set in the cycle after RD with the empty flag high, and holds until the next IDLE → HDR transition.

## Test plan
- NCH=8, SBYTES=2, all channels en, len=2, ch i data 0x0i01 then 0x0i02, info/smpr/kind = 01/02/03, tx_ready=1.
  - Expect 39 bytes: 55 AA 01 02 03 08, then 00 01 00 02 01 01 01 02 … 07 02, then the checksum. tx_last only on byte 39.
  - Expect 16 fifo_rd pulses.
- ch_en=0, fs_fifo pulsed → 55 AA 01 02 03 00 06; fd_fifo high until fs_fifo=0.
- ch_en=0x05, len0=3, len2=1, random tx_ready 50%.
  - Byte sequence identical to the tx_ready=1 run, N=0x02.
  - tx_data stable while stalled.
  - Exactly 3 reads on ch0, then 1 on ch2.
- fifo_empty[3]=1 with ch3 len=1 → no fifo_rd[3]; ch3 emits 00 00; err=1 after the frame; frame length unchanged.
  - The next frame with the FIFO non-empty clears err.
- ch_len=200 with MAXS=32 → exactly 32 samples read from that channel.
- rst asserted during DAT of ch4 → all outputs return to reset values next edge; a new fs_fifo starts a clean frame from 0x55.
